// File: rtl/lavar_pkg.sv
// Shared definitions for the washing-machine controller: default widths,
// the retention FSM encoding and the default-width snapshot record.
package lavar_pkg;

    localparam int LAV_STATE_W = 4;
    localparam int LAV_TIMER_W = 8;

    typedef enum logic [1:0] {
        INICIO   = 2'd0,
        NORMAL   = 2'd1,
        FALHA    = 2'd2,
        RESTAURA = 2'd3
    } fsm_t;

    typedef struct packed {
        logic [LAV_STATE_W-1:0] estado;
        logic [LAV_TIMER_W-1:0] tempo;
        logic                   paridade;
    } snap_t;

endpackage

// File: rtl/sincroniza_debounce.sv
// Two-flop synchroniser followed by a level debouncer: the filtered output
// only follows the synchronised input after DEB_CYC consecutive disagreeing cycles.
module sincroniza_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic sinc,
    output logic filtrado
);

    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);

    logic          s1_q;
    logic          s2_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q <= entrada;
            s2_q <= s1_q;
            // Any cycle of agreement restarts the count, so short dips never toggle.
            if (s2_q != filt_q) begin
                if (cnt_q == CW'(DEB_CYC - 1)) begin
                    filt_q <= s2_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign sinc     = s2_q;
    assign filtrado = filt_q;

endmodule

// File: rtl/protecao_retencao.sv
// Power-fail retention controller: shadows the last good cycle state, commits it
// to a parity-protected history ring on a confirmed supply loss, and offers it back.
module protecao_retencao
    import lavar_pkg::*;
#(
    parameter int STATE_W = LAV_STATE_W,
    parameter int TIMER_W = LAV_TIMER_W,
    parameter int DEPTH   = 4,
    parameter int DEB_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     energia,
    input  logic [STATE_W-1:0]       estado,
    input  logic [TIMER_W-1:0]       tempo,
    input  logic                     restaurar_ack,
    input  logic                     limpar,
    input  logic [$clog2(DEPTH)-1:0] consulta_idx,
    output logic                     energia_ok,
    output logic                     restaurar_valid,
    output logic [STATE_W-1:0]       estado_salvo,
    output logic [TIMER_W-1:0]       tempo_salvo,
    output logic                     erro_paridade,
    output logic                     snapshot_valido,
    output logic [CNT_W-1:0]         falhas_cnt,
    output logic [STATE_W-1:0]       hist_estado,
    output logic [TIMER_W-1:0]       hist_tempo,
    output logic                     hist_valido,
    output fsm_t                     estado_fsm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] ENT_MAX = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [STATE_W-1:0] estado;
        logic [TIMER_W-1:0] tempo;
        logic               paridade;
    } slot_t;

    logic               e_s;
    logic               ok;

    fsm_t               state_q;
    logic [STATE_W-1:0] shadow_estado_q;
    logic [TIMER_W-1:0] shadow_tempo_q;
    slot_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W:0]     entries_q;
    logic [CNT_W-1:0]   falhas_q;
    logic               snap_valid_q;
    logic               rest_valid_q;
    logic [STATE_W-1:0] estado_salvo_q;
    logic [TIMER_W-1:0] tempo_salvo_q;
    logic               erro_par_q;

    logic [PTR_W-1:0]   newest_ptr;
    logic [PTR_W-1:0]   hist_ptr;
    slot_t              newest;
    logic               newest_bad;

    sincroniza_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_energia (
        .clk      (clk),
        .reset    (reset),
        .entrada  (energia),
        .sinc     (e_s),
        .filtrado (ok)
    );

    assign newest_ptr = wr_ptr_q - PTR_W'(1);
    assign hist_ptr   = wr_ptr_q - PTR_W'(1) - consulta_idx;
    assign newest     = mem_q[newest_ptr];
    assign newest_bad = newest.paridade != (^{newest.estado, newest.tempo});

    // The shadow tracks live state only while the synchronised supply is good,
    // so values sampled during a brown-out are never the ones committed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_estado_q <= '0;
            shadow_tempo_q  <= '0;
        end else if (e_s && state_q == NORMAL) begin
            shadow_estado_q <= estado;
            shadow_tempo_q  <= tempo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= INICIO;
            wr_ptr_q       <= '0;
            entries_q      <= '0;
            falhas_q       <= '0;
            snap_valid_q   <= 1'b0;
            rest_valid_q   <= 1'b0;
            estado_salvo_q <= '0;
            tempo_salvo_q  <= '0;
            erro_par_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                INICIO: begin
                    if (ok) begin
                        state_q <= NORMAL;
                    end
                end
                NORMAL: begin
                    if (!ok) begin
                        mem_q[wr_ptr_q] <= '{estado:   shadow_estado_q,
                                             tempo:    shadow_tempo_q,
                                             paridade: ^{shadow_estado_q, shadow_tempo_q}};
                        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                        if (entries_q != ENT_MAX) begin
                            entries_q <= entries_q + (PTR_W + 1)'(1);
                        end
                        if (falhas_q != '1) begin
                            falhas_q <= falhas_q + CNT_W'(1);
                        end
                        snap_valid_q <= 1'b1;
                        state_q      <= FALHA;
                    end else if (limpar) begin
                        wr_ptr_q     <= '0;
                        entries_q    <= '0;
                        falhas_q     <= '0;
                        snap_valid_q <= 1'b0;
                    end
                end
                FALHA: begin
                    if (ok) begin
                        rest_valid_q   <= 1'b1;
                        estado_salvo_q <= newest.estado;
                        tempo_salvo_q  <= newest.tempo;
                        erro_par_q     <= newest_bad;
                        state_q        <= RESTAURA;
                    end
                end
                RESTAURA: begin
                    // A supply loss outranks a simultaneous acknowledge; the shadow is
                    // stale here, so nothing new is written and the slot is re-offered.
                    if (!ok) begin
                        rest_valid_q <= 1'b0;
                        if (falhas_q != '1) begin
                            falhas_q <= falhas_q + CNT_W'(1);
                        end
                        state_q <= FALHA;
                    end else if (restaurar_ack) begin
                        rest_valid_q <= 1'b0;
                        state_q      <= NORMAL;
                    end else begin
                        estado_salvo_q <= newest.estado;
                        tempo_salvo_q  <= newest.tempo;
                        erro_par_q     <= newest_bad;
                    end
                end
                default: state_q <= INICIO;
            endcase
        end
    end

    assign energia_ok      = ok;
    assign restaurar_valid = rest_valid_q;
    assign estado_salvo    = estado_salvo_q;
    assign tempo_salvo     = tempo_salvo_q;
    assign erro_paridade   = erro_par_q;
    assign snapshot_valido = snap_valid_q;
    assign falhas_cnt      = falhas_q;
    assign hist_estado     = mem_q[hist_ptr].estado;
    assign hist_tempo      = mem_q[hist_ptr].tempo;
    assign hist_valido     = ({1'b0, consulta_idx} < entries_q);
    assign estado_fsm      = state_q;

endmodule

// File: tb/tb_protecao_retencao.sv
// Directed bench for the power-fail retention controller: debounce latency,
// commit/restore handshake, glitch rejection, ring wrap, parity and clear.
module tb_protecao_retencao;
    import lavar_pkg::*;

    logic       clk;
    logic       reset;
    logic       energia;
    logic [3:0] estado;
    logic [7:0] tempo;
    logic       restaurar_ack;
    logic       limpar;
    logic [1:0] consulta_idx;
    logic       energia_ok;
    logic       restaurar_valid;
    logic [3:0] estado_salvo;
    logic [7:0] tempo_salvo;
    logic       erro_paridade;
    logic       snapshot_valido;
    logic [7:0] falhas_cnt;
    logic [3:0] hist_estado;
    logic [7:0] hist_tempo;
    logic       hist_valido;
    fsm_t       estado_fsm;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] est;
        logic [7:0] tmp;
        logic [7:0] exp_falhas;
    } cut_vec_t;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] exp_est;
        logic [7:0] exp_tmp;
        logic       exp_val;
    } hist_vec_t;

    cut_vec_t  cv [6];
    hist_vec_t hv [4];

    protecao_retencao dut (
        .clk             (clk),
        .reset           (reset),
        .energia         (energia),
        .estado          (estado),
        .tempo           (tempo),
        .restaurar_ack   (restaurar_ack),
        .limpar          (limpar),
        .consulta_idx    (consulta_idx),
        .energia_ok      (energia_ok),
        .restaurar_valid (restaurar_valid),
        .estado_salvo    (estado_salvo),
        .tempo_salvo     (tempo_salvo),
        .erro_paridade   (erro_paridade),
        .snapshot_valido (snapshot_valido),
        .falhas_cnt      (falhas_cnt),
        .hist_estado     (hist_estado),
        .hist_tempo      (hist_tempo),
        .hist_valido     (hist_valido),
        .estado_fsm      (estado_fsm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ok(input logic lvl);
        for (int i = 0; i < 20 && energia_ok !== lvl; i++) tick(1);
        check("energia_ok_wait", 32'(energia_ok), 32'(lvl));
    endtask

    // Cut the supply; the live inputs are trashed once the synchroniser has seen the drop.
    task automatic cortar(input logic [3:0] lixo);
        energia = 1'b0;
        tick(3);
        estado = lixo;
        tempo  = ~tempo;
        wait_ok(1'b0);
        tick(1);
    endtask

    task automatic religar();
        energia = 1'b1;
        wait_ok(1'b1);
        tick(1);
    endtask

    task automatic confirmar();
        restaurar_ack = 1'b1;
        tick(1);
        restaurar_ack = 1'b0;
    endtask

    task automatic ler_hist(input logic [1:0] idx);
        consulta_idx = idx;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b0; energia = 1'b0; estado = '0; tempo = '0;
        restaurar_ack = 1'b0; limpar = 1'b0; consulta_idx = '0;

        for (int i = 0; i < 6; i++) begin
            cv[i].est        = 4'(i + 1);
            cv[i].tmp        = 8'(16 * (i + 1));
            cv[i].exp_falhas = 8'(i + 1);
        end
        hv[0] = '{idx: 2'd0, exp_est: 4'd6, exp_tmp: 8'h60, exp_val: 1'b1};
        hv[1] = '{idx: 2'd1, exp_est: 4'd5, exp_tmp: 8'h50, exp_val: 1'b1};
        hv[2] = '{idx: 2'd2, exp_est: 4'd4, exp_tmp: 8'h40, exp_val: 1'b1};
        hv[3] = '{idx: 2'd3, exp_est: 4'd3, exp_tmp: 8'h30, exp_val: 1'b1};

        tick(2);
        check("rst_energia_ok", 32'(energia_ok), 0);
        check("rst_restaurar_valid", 32'(restaurar_valid), 0);
        check("rst_estado_salvo", 32'(estado_salvo), 0);
        check("rst_tempo_salvo", 32'(tempo_salvo), 0);
        check("rst_erro_paridade", 32'(erro_paridade), 0);
        check("rst_snapshot_valido", 32'(snapshot_valido), 0);
        check("rst_falhas_cnt", 32'(falhas_cnt), 0);
        check("rst_hist_estado", 32'(hist_estado), 0);
        check("rst_hist_tempo", 32'(hist_tempo), 0);
        check("rst_hist_valido", 32'(hist_valido), 0);
        check("rst_fsm", 32'(estado_fsm), 32'(INICIO));

        // Power-up: energia_ok rises exactly 2 + DEB_CYC edges after the raw edge.
        reset = 1'b1;
        tick(1);
        energia = 1'b1;
        tick(5);
        check("pwrup_ok_early", 32'(energia_ok), 0);
        tick(1);
        check("pwrup_ok_on_time", 32'(energia_ok), 1);
        tick(1);
        check("pwrup_fsm_normal", 32'(estado_fsm), 32'(NORMAL));
        check("pwrup_no_snapshot", 32'(snapshot_valido), 0);
        check("pwrup_falhas", 32'(falhas_cnt), 0);

        // First real cut, followed by restore handshake.
        estado = 4'd5; tempo = 8'h3C;
        tick(2);
        cortar(4'hF);
        check("cut1_fsm_falha", 32'(estado_fsm), 32'(FALHA));
        check("cut1_snapshot_valido", 32'(snapshot_valido), 1);
        check("cut1_falhas", 32'(falhas_cnt), 1);
        ler_hist(2'd0);
        check("cut1_hist_estado", 32'(hist_estado), 5);
        check("cut1_hist_tempo", 32'(hist_tempo), 32'h3C);
        check("cut1_hist_valido0", 32'(hist_valido), 1);
        ler_hist(2'd1);
        check("cut1_hist_valido1", 32'(hist_valido), 0);
        check("cut1_no_valid_yet", 32'(restaurar_valid), 0);
        religar();
        check("rest1_valid", 32'(restaurar_valid), 1);
        check("rest1_estado", 32'(estado_salvo), 5);
        check("rest1_tempo", 32'(tempo_salvo), 32'h3C);
        check("rest1_paridade", 32'(erro_paridade), 0);
        confirmar();
        check("rest1_valid_drop", 32'(restaurar_valid), 0);
        check("rest1_fsm_normal", 32'(estado_fsm), 32'(NORMAL));
        check("rest1_salvo_hold", 32'(estado_salvo), 5);

        // Glitch: a two-cycle dip must not commit anything.
        estado = 4'd2; tempo = 8'h22;
        tick(3);
        energia = 1'b0; estado = 4'd9; tempo = 8'h99;
        tick(2);
        energia = 1'b1; estado = 4'd7; tempo = 8'h77;
        tick(10);
        check("glitch_ok_stays", 32'(energia_ok), 1);
        check("glitch_falhas", 32'(falhas_cnt), 1);
        check("glitch_fsm", 32'(estado_fsm), 32'(NORMAL));
        cortar(4'h0);
        check("cut2_falhas", 32'(falhas_cnt), 2);
        ler_hist(2'd0);
        check("cut2_hist_estado", 32'(hist_estado), 7);
        check("cut2_hist_tempo", 32'(hist_tempo), 32'h77);
        religar();
        check("rest2_estado", 32'(estado_salvo), 7);
        confirmar();

        // Loss during restore: no new snapshot, counter bumps, same slot re-offered.
        estado = 4'd3; tempo = 8'h33;
        tick(3);
        cortar(4'hA);
        check("cut3_falhas", 32'(falhas_cnt), 3);
        religar();
        check("rest3_valid", 32'(restaurar_valid), 1);
        check("rest3_estado", 32'(estado_salvo), 3);
        energia = 1'b0;
        wait_ok(1'b0);
        tick(1);
        check("loss_valid_drop", 32'(restaurar_valid), 0);
        check("loss_falhas", 32'(falhas_cnt), 4);
        check("loss_fsm_falha", 32'(estado_fsm), 32'(FALHA));
        limpar = 1'b1;
        tick(1);
        limpar = 1'b0;
        check("limpar_ignored_falhas", 32'(falhas_cnt), 4);
        check("limpar_ignored_snap", 32'(snapshot_valido), 1);
        ler_hist(2'd2);
        check("loss_entries_idx2", 32'(hist_valido), 1);
        ler_hist(2'd3);
        check("loss_entries_idx3", 32'(hist_valido), 0);
        religar();
        check("reoffer_valid", 32'(restaurar_valid), 1);
        check("reoffer_estado", 32'(estado_salvo), 3);
        check("reoffer_tempo", 32'(tempo_salvo), 32'h33);
        confirmar();
        check("reoffer_fsm_normal", 32'(estado_fsm), 32'(NORMAL));

        // Parity: corrupt the stored parity bit of the newest slot (slot 3).
        estado = 4'd6; tempo = 8'h5A;
        tick(3);
        cortar(4'h1);
        check("cut4_falhas", 32'(falhas_cnt), 5);
        dut.mem_q[3].paridade = ~dut.mem_q[3].paridade;
        religar();
        check("par_erro", 32'(erro_paridade), 1);
        check("par_estado", 32'(estado_salvo), 6);
        check("par_tempo", 32'(tempo_salvo), 32'h5A);
        confirmar();
        limpar = 1'b1;
        tick(1);
        limpar = 1'b0;
        check("clr_snapshot", 32'(snapshot_valido), 0);
        check("clr_falhas", 32'(falhas_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            ler_hist(2'(i));
            check("clr_hist_valido", 32'(hist_valido), 0);
        end

        // Wrap: six cuts into a four-deep ring.
        for (int i = 0; i < 6; i++) begin
            estado = cv[i].est; tempo = cv[i].tmp;
            tick(3);
            cortar(4'hE);
            check("wrap_falhas", 32'(falhas_cnt), 32'(cv[i].exp_falhas));
            religar();
            check("wrap_rest_estado", 32'(estado_salvo), 32'(cv[i].est));
            check("wrap_rest_tempo", 32'(tempo_salvo), 32'(cv[i].tmp));
            confirmar();
        end
        check("wrap_paridade_ok", 32'(erro_paridade), 0);
        for (int i = 0; i < 4; i++) begin
            ler_hist(hv[i].idx);
            check("wrap_hist_estado", 32'(hist_estado), 32'(hv[i].exp_est));
            check("wrap_hist_tempo", 32'(hist_tempo), 32'(hv[i].exp_tmp));
            check("wrap_hist_valido", 32'(hist_valido), 32'(hv[i].exp_val));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/protecao_retencao.md
Name: protecao_retencao

Overview:
- Parametrised power-fail retention controller for the washing-machine controller; successor to the single-register power-loss latch.
- Synchronises and debounces `energia` and keeps a shadow of the last good `estado`/`tempo`.
- On a confirmed power loss, it commits that shadow into a parity-protected history ring, then runs a restore handshake once power is back.
- Sits between the cycle FSM/timer and the main controller's restore logic.

Parameters:
- STATE_W, 4, width of cycle state.
- TIMER_W, 8, width of remaining-time value.
- DEPTH, 4, history slots (power of two, >=2).
- DEB_CYC, 4, consecutive cycles needed to accept an `energia` level change (>=1).
- CNT_W, 8, width of saturating failure counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- energia  in  1  raw supply-good, asynchronous to clk.
- estado  in  STATE_W  current cycle state.
- tempo  in  TIMER_W  current remaining time.
- restaurar_ack  in  1  controller has consumed the restore data.
- limpar  in  1  clear history/counters (honoured in NORMAL only).
- consulta_idx  in  log2(DEPTH)  history read index, 0 = newest.
- energia_ok  out  1  debounced supply-good.
- restaurar_valid  out  1  restore data valid.
- estado_salvo  out  STATE_W  newest snapshot state.
- tempo_salvo  out  TIMER_W  newest snapshot time.
- erro_paridade  out  1  newest snapshot fails its parity check.
- snapshot_valido  out  1  at least one snapshot is stored.
- falhas_cnt  out  CNT_W  confirmed power failures, saturating.
- hist_estado  out  STATE_W  history slot selected by consulta_idx.
- hist_tempo  out  TIMER_W  history slot selected by consulta_idx.
- hist_valido  out  1  consulta_idx < stored entry count.

Behaviour:
- Reset values:
  - All outputs 0.
  - Sync flops, debounce counter, shadow, wr_ptr, entry count and history memory all 0.
  - FSM = INICIO.
- Synchronisation and debounce:
  - 2-FF synchroniser produces `e_s`.
  - The debounce counter increments while `e_s != energia_ok`; it is cleared when they are equal.
  - When the count reaches DEB_CYC, `energia_ok` toggles and the counter clears.
  - Latency from a raw edge to an `energia_ok` edge = 2 + DEB_CYC cycles.
- Shadow:
  - Loads {estado, tempo} every cycle while `e_s`=1 and FSM = NORMAL.
  - Freezes as soon as `e_s`=0, so brown-out glitch values are never committed.
  - If `e_s` returns to 1 before debounce completes, shadow updates resume with no commit.
- FSM states:
  - INICIO: waits for `energia_ok` rise, then goes to NORMAL. No snapshot is taken.
  - NORMAL: on `energia_ok` fall:
    - write {shadow, parity=^shadow} to slot wr_ptr;
    - wr_ptr <= wr_ptr+1 mod DEPTH;
    - entries <= min(entries+1, DEPTH), with the oldest slot overwritten when full;
    - falhas_cnt++ (saturates at all-ones);
    - snapshot_valido <= 1;
    - go to FALHA.
  - FALHA: on `energia_ok` rise, go to RESTAURA.
  - RESTAURA:
    - restaurar_valid = 1.
    - estado_salvo/tempo_salvo come from slot wr_ptr-1.
    - erro_paridade = stored parity != recomputed parity.
    - On restaurar_ack: restaurar_valid <= 0, go to NORMAL. The shadow reloads next cycle.
    - On `energia_ok` fall before ack: restaurar_valid <= 0, falhas_cnt++, go to FALHA. No new snapshot is written (the shadow is stale). The same slot is re-offered on the next restore.
    - If ack and fall occur in the same cycle, the fall wins.
- Outputs:
  - restaurar_valid, estado_salvo, tempo_salvo and erro_paridade are registered. estado_salvo/tempo_salvo hold their values outside RESTAURA.
  - hist_* outputs are combinational from slot (wr_ptr-1-consulta_idx) mod DEPTH.
  - hist_valido = consulta_idx < entries.
- limpar in NORMAL, effective next cycle:
  - entries, wr_ptr, falhas_cnt and snapshot_valido are cleared.
  - Memory contents are retained, but hist_valido reads 0.
  - limpar is ignored in every other state.
- Reset mid-operation: forces all reset values, including a cleared history. Retention across reset is the non-volatile layer's job.

Decomposition:
- Shared package `lavar_pkg`:
  - state-width constants;
  - FSM enum {INICIO, NORMAL, FALHA, RESTAURA};
  - snapshot record type {estado, tempo, paridade}.
- One natural sub-module: `sincroniza_debounce` (2-FF synchroniser plus DEB_CYC debouncer, parameter DEB_CYC), reusable for the door and level sensors.

Test Plan:
- Power-up: reset low, release, energia=1 at cycle 3 -> energia_ok=1 at cycle 9 (DEB_CYC=4); FSM = NORMAL; no snapshot; falhas_cnt=0.
- Power cut: estado=5, tempo=0x3C, then energia=0 for 10 cycles -> slot0={5,0x3C}; snapshot_valido=1; falhas_cnt=1. Restore energia -> restaurar_valid=1 with estado_salvo=5, tempo_salvo=0x3C, erro_paridade=0; drop restaurar_valid one cycle after ack.
- Glitch rejection: energia low for 2 cycles, with estado changing to 9 during the dip -> no commit; falhas_cnt unchanged; the next real cut stores the post-glitch value, not a dip-time value.
- Wrap: 6 cuts with estado 1..6, DEPTH=4 -> consulta_idx 0..3 reads 6,5,4,3; hist_valido=1 for all four; falhas_cnt=6.
- Loss during restore: energia falls in RESTAURA before ack -> restaurar_valid=0; falhas_cnt+1; entries unchanged; next restore re-offers the same snapshot.
- Parity and clear: bench forces one stored bit of the newest slot -> erro_paridade=1 in RESTAURA. After ack, limpar=1 -> snapshot_valido=0, falhas_cnt=0, all hist_valido=0.
